fifo_stream_reader: RTL and testbench

//  Read-side engine for a FifoController-managed buffer: pops words from the FIFO RAM and

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_stream_reader_skid_buffer.sv | 54 +++++
 rtl/fifo_stream_reader.sv | 86 ++++++++
 tb/tb_fifo_stream_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side stream engine: occupancy type, reader FSM states
// and the output buffer depth.
package fifo_pkg;

  typedef logic [1:0] occ_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } reader_state_t;

  localparam int BUF_ENTRIES = 2;

endpackage

// File: rtl/fifo_stream_reader_skid_buffer.sv
// Two-entry in-order skid buffer. The head register drives the stream output directly;
// push and pop may occur in the same cycle.
module stream_skid_buffer
  import fifo_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output occ_t         occ
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  occ_t         occ_q;

  // The caller's credit accounting never pushes into a full buffer without a pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= din;
          else               tail_q <= din;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= din;
          end else begin
            head_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = head_q;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine for a FifoController buffer: credit-based prefetch from the RAM into a
// 2-entry skid buffer feeding a valid/ready stream. Optional frame tagging via FIFO_READER_LAST_EN.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [DEPTH-1:0] fifo_read_addr,
  output logic             fifo_read_enable,
  output logic [DEPTH-1:0] mem_raddr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  logic          inflight;
  logic          handshake;
  logic          last_in;
  logic [2:0]    occ_next;
  logic [WIDTH:0] head;
  occ_t          occ;
  reader_state_t state;
  reader_state_t state_next;

  assign m_valid   = (occ != 2'd0);
  assign handshake = m_valid & m_ready;

  // Credit counts the slot freed by this cycle's handshake so a steady stream pops every cycle.
  assign occ_next         = {1'b0, occ} + {2'b0, inflight} - {2'b0, handshake};
  assign fifo_read_enable = enable & ~fifo_empty & (occ_next < 3'(BUF_ENTRIES));
  assign mem_raddr        = fifo_read_addr + DEPTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) inflight <= 1'b0;
    else        inflight <= fifo_read_enable;
  end

  stream_skid_buffer #(
    .W(WIDTH + 1)
  ) u_buffer (
    .clk  (clk),
    .reset(reset),
    .push (inflight),
    .pop  (handshake),
    .din  ({last_in, mem_rdata}),
    .head (head),
    .occ  (occ)
  );

  assign m_data = head[WIDTH-1:0];
  assign m_last = head[WIDTH];

`ifdef FIFO_READER_LAST_EN
  logic [15:0] frame_count;

  // Words are tagged on entry; the buffer is in order, so this equals the handshake count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        frame_count <= '0;
    else if (inflight) frame_count <= last_in ? 16'd0 : frame_count + 16'd1;
  end

  assign last_in = (frame_count == 16'(FRAME_LEN - 1));
`else
  assign last_in = 1'b0;
`endif

  always_comb begin
    state_next = STREAM;
    if ((occ_next == 3'd0) && !fifo_read_enable) state_next = IDLE;
    else if (!enable)                            state_next = DRAIN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural FifoController and RAM.
// Define FIFO_READER_LAST_EN to expect frame tags (FRAME_LEN=3) on words 3, 6, ...
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  localparam int DEPTH     = 4;
  localparam int WIDTH     = 16;
  localparam int FRAME_LEN = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             m_ready = 1'b0;
  logic             fifo_empty;
  logic             fifo_read_enable;
  logic [DEPTH-1:0] rd_ptr;
  logic [DEPTH-1:0] wr_ptr = '0;
  logic [DEPTH-1:0] base_ptr = '0;
  logic [DEPTH-1:0] mem_raddr;
  logic [WIDTH-1:0] mem [2**DEPTH];
  logic [WIDTH-1:0] mem_rdata;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops, first_pop, last_pop, first_valid, recv, word_idx;
  logic [WIDTH:0]   exp_q[$];
  logic [DEPTH-1:0] raddr_q[$];
  logic [WIDTH:0]   exp_word;
  logic             hold_pending = 1'b0;
  logic [WIDTH-1:0] hold_data = '0;

  fifo_stream_reader #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read_addr(rd_ptr), .fifo_read_enable(fifo_read_enable),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Controller model: rd_ptr is the last consumed slot, wr_ptr the last written slot.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk or negedge reset) begin
    if (!reset)                rd_ptr <= base_ptr;
    else if (fifo_read_enable) rd_ptr <= rd_ptr + 4'd1;
  end
  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic lastFor(int idx);
`ifdef FIFO_READER_LAST_EN
    return (idx % FRAME_LEN) == FRAME_LEN - 1;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: event statistics, stall stability and scoreboard comparison.
  always @(negedge clk) begin
    if (reset) begin
      if (fifo_read_enable) begin
        if (pops == 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
        raddr_q.push_back(mem_raddr);
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (hold_pending && m_valid) checkOutput("stall_hold", 32'(m_data), 32'(hold_data));
      if (m_valid && m_ready) begin
        recv++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: actual 0x%0h required none", m_data);
        end else begin
          exp_word = exp_q.pop_front();
          checkOutput("word_data", 32'(m_data), 32'(exp_word[WIDTH-1:0]));
          checkOutput("word_last", 32'(m_last), 32'(exp_word[WIDTH]));
        end
      end
      hold_pending = m_valid && !m_ready;
      hold_data    = m_data;
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearStats();
    pops = 0; first_pop = -1; last_pop = -1; first_valid = -1; recv = 0; word_idx = 0;
    raddr_q.delete();
  endtask

  task automatic checkResetOutputs(string tag);
    checkOutput({tag, "_rd_en"}, 32'(fifo_read_enable), 0);
    checkOutput({tag, "_valid"}, 32'(m_valid), 0);
    checkOutput({tag, "_data"},  32'(m_data), 0);
    checkOutput({tag, "_last"},  32'(m_last), 0);
  endtask

  task automatic applyStimulus(logic [DEPTH-1:0] base);
    enable = 1'b0; m_ready = 1'b0;
    base_ptr = base; wr_ptr = base;
    reset = 1'b0;
    exp_q.delete();
    #1 checkResetOutputs("reset");
    tick(2);
    reset = 1'b1;
    clearStats();
    tick(1);
  endtask

  task automatic preload(logic [WIDTH-1:0] word, bit expect_out);
    logic [DEPTH-1:0] slot;
    slot = wr_ptr + 4'd1;
    mem[slot] = word;
    wr_ptr = slot;
    if (expect_out) begin
      exp_q.push_back({lastFor(word_idx), word});
      word_idx++;
    end
  endtask

  task automatic waitDrain(string name, int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput({name, "_drained"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ready_pat;
    for (int i = 0; i < 2**DEPTH; i++) mem[i] = '0;
    tick(1);

    $display("[TB] test 1: back-to-back streaming");
    applyStimulus(4'd0);
    for (int i = 1; i <= 5; i++) preload(16'(i * 16'h0011), 1'b1);
    enable = 1'b1; m_ready = 1'b1;
    waitDrain("t1", 30);
    tick(3);
    checkOutput("t1_pops", 32'(pops), 5);
    checkOutput("t1_pop_span", 32'(last_pop - first_pop), 4);
    checkOutput("t1_latency", 32'(first_valid - first_pop), 2);
    checkOutput("t1_recv", 32'(recv), 5);

    $display("[TB] test 2: sink stall");
    applyStimulus(4'd0);
    for (int i = 1; i <= 4; i++) preload(16'(i * 16'h0011), 1'b1);
    enable = 1'b1; m_ready = 1'b0;
    tick(10);
    checkOutput("t2_pops_stalled", 32'(pops), 2);
    checkOutput("t2_valid", 32'(m_valid), 1);
    checkOutput("t2_head", 32'(m_data), 32'h0011);
    m_ready = 1'b1;
    waitDrain("t2", 30);
    tick(3);
    checkOutput("t2_recv", 32'(recv), 4);
    checkOutput("t2_pops", 32'(pops), 4);

    $display("[TB] test 3: address wrap");
    applyStimulus(4'd14);
    preload(16'hA001, 1'b1); preload(16'hA002, 1'b1); preload(16'hA003, 1'b1);
    enable = 1'b1; m_ready = 1'b1;
    waitDrain("t3", 30);
    checkOutput("t3_pops", 32'(raddr_q.size()), 3);
    if (raddr_q.size() == 3) begin
      checkOutput("t3_raddr0", 32'(raddr_q[0]), 15);
      checkOutput("t3_raddr1", 32'(raddr_q[1]), 0);
      checkOutput("t3_raddr2", 32'(raddr_q[2]), 1);
    end

    $display("[TB] test 4: enable drop after a pop");
    applyStimulus(4'd0);
    preload(16'h0011, 1'b1); preload(16'h0022, 1'b0); preload(16'h0033, 1'b0);
    enable = 1'b1; m_ready = 1'b1;
    tick(1);
    enable = 1'b0;
    waitDrain("t4", 20);
    tick(8);
    checkOutput("t4_pops", 32'(pops), 1);
    checkOutput("t4_recv", 32'(recv), 1);
    checkOutput("t4_state_idle", 32'(dut.state), 32'(IDLE));
    checkOutput("t4_rd_en_low", 32'(fifo_read_enable), 0);

    $display("[TB] test 5: reset mid-stream");
    applyStimulus(4'd0);
    for (int i = 1; i <= 5; i++) preload(16'(i * 16'h0011), 1'b1);
    enable = 1'b1; m_ready = 1'b0;
    tick(2);
    checkOutput("t5_valid_before", 32'(m_valid), 1);
    reset = 1'b0;
    wr_ptr = base_ptr;
    exp_q.delete();
    #1 checkResetOutputs("t5_async");
    tick(2);
    reset = 1'b1;
    clearStats();
    tick(5);
    checkOutput("t5_no_pop", 32'(pops), 0);
    checkOutput("t5_no_stale", 32'(first_valid), 32'(-1));
    preload(16'h0BEE, 1'b1);
    m_ready = 1'b1;
    waitDrain("t5", 20);
    checkOutput("t5_recv", 32'(recv), 1);

    $display("[TB] test 6: framing under irregular ready");
    applyStimulus(4'd0);
    for (int i = 1; i <= 7; i++) preload(16'(16'h0100 + i), 1'b1);
    enable = 1'b1;
    ready_pat = 16'b1011_0010_1101_0110;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      m_ready = ready_pat[i % 16];
      tick(1);
    end
    m_ready = 1'b1;
    waitDrain("t6", 20);
    checkOutput("t6_recv", 32'(recv), 7);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
